// File: rtl/mem_arbiter.sv
// Arbiter between instruction-fetch and load/store ports sharing one
// synchronous BRAM; data wins by default, a starvation counter forces fetch.
module mem_arbiter #(
  parameter int unsigned MEM_ADDR_W = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic [3:0]            d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] starve_cnt;
  logic             rsp_if;
  logic             rsp_d;
  logic             force_if;
  logic             gnt_if;
  logic             gnt_d;

  // Per-cycle grant; suppressed entirely while reset is asserted
  always_comb begin
    force_if = 1'b0;
    gnt_if   = 1'b0;
    gnt_d    = 1'b0;
    if (rstn) begin
      force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
      gnt_if   = force_if || (if_req && !d_req);
      gnt_d    = d_req && !gnt_if;
    end
  end

  assign if_ready  = gnt_if;
  assign d_ready   = gnt_d;
  assign mem_en    = gnt_if || gnt_d;
  assign mem_we    = gnt_d ? d_we : 4'b0000;
  assign mem_addr  = gnt_d ? d_addr[MEM_ADDR_W+1:2] : if_addr[MEM_ADDR_W+1:2];
  assign mem_wdata = d_wdata;

  assign if_rvalid = rsp_if;
  assign d_rvalid  = rsp_d;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // Response tracking and fetch starvation counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_if     <= 1'b0;
      rsp_d      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rsp_if <= gnt_if;
      rsp_d  <= gnt_d && (d_we == 4'b0000);
      if (gnt_if || !if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt < CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Byte-offset and out-of-range address bits are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MEM_ADDR_W+2], if_addr[1:0],
                              d_addr[31:MEM_ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle BRAM.
module tb_mem_arbiter;

  localparam int unsigned MEM_ADDR_W = 12;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] ram [0:(1<<MEM_ADDR_W)-1];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_ADDR_W(MEM_ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Read-first synchronous RAM with byte enables
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 4'b0000, 32'h8, 32'h0);
    #1;
    total++; if ({if_ready, d_ready, mem_en} !== 3'b000) $display("FAIL reset_grants: got %b want 000", {if_ready, d_ready, mem_en}); else passed++;
    total++; if (mem_we !== 4'b0000) $display("FAIL reset_mem_we: got %b want 0000", mem_we); else passed++;
    @(posedge clk); #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {if_rvalid, d_rvalid}); else passed++;
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    #1;
    total++; if (if_ready !== 1'b1 || mem_addr !== 12'h000) $display("FAIL release_fetch: got ready=%b addr=%h want 1/000", if_ready, mem_addr); else passed++;
    @(posedge clk); #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11) $display("FAIL release_rdata: got v=%b d=%h want 1/00000011", if_rvalid, if_rdata); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only;
    logic [31:0] expd [3];
    expd[0] = 32'h11; expd[1] = 32'h22; expd[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'(4*i), 1'b0, 4'b0000, 32'h0, 32'h0);
      #1;
      total++; if (if_ready !== 1'b1 || d_ready !== 1'b0 || mem_we !== 4'b0000) $display("FAIL fetch_ready[%0d]: got if=%b d=%b we=%b want 1/0/0000", i, if_ready, d_ready, mem_we); else passed++;
      @(posedge clk); #1;
      total++; if (if_rvalid !== 1'b1 || if_rdata !== expd[i]) $display("FAIL fetch_rdata[%0d]: got v=%b d=%h want 1/%h", i, if_rvalid, if_rdata, expd[i]); else passed++;
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    #1;
    total++; if (mem_en !== 1'b0) $display("FAIL idle_mem_en: got %b want 0", mem_en); else passed++;
    @(posedge clk); #1;
    total++; if (if_rvalid !== 1'b0) $display("FAIL fetch_rvalid_drop: got %b want 0", if_rvalid); else passed++;
  endtask

  task automatic test_store_load;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 4'b1111, 32'h40, 32'hDEADBEEF);
    #1;
    total++; if (d_ready !== 1'b1 || mem_we !== 4'b1111 || mem_addr !== 12'h010) $display("FAIL store_drive: got r=%b we=%b a=%h want 1/1111/010", d_ready, mem_we, mem_addr); else passed++;
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b0) $display("FAIL store_no_rvalid: got %b want 0", d_rvalid); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 4'b0000, 32'h40, 32'h0);
    #1;
    total++; if (d_ready !== 1'b1 || mem_we !== 4'b0000) $display("FAIL load_drive: got r=%b we=%b want 1/0000", d_ready, mem_we); else passed++;
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got v=%b d=%h want 1/deadbeef", d_rvalid, d_rdata); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 4'b0010, 32'h40, 32'h0000AA00);
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b0) $display("FAIL bstore_no_rvalid: got %b want 0", d_rvalid); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 4'b0000, 32'h40, 32'h0);
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADAAEF) $display("FAIL bload_rdata: got v=%b d=%h want 1/deadaaef", d_rvalid, d_rdata); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b0) $display("FAIL load_rvalid_drop: got %b want 0", d_rvalid); else passed++;
  endtask

  task automatic test_collision;
    logic exp_if;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h4, 1'b1, 4'b0000, 32'h8, 32'h0);
      exp_if = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
      #1;
      total++; if (if_ready !== exp_if || d_ready !== !exp_if) $display("FAIL collide_grant[%0d]: got if=%b d=%b want if=%b d=%b", i, if_ready, d_ready, exp_if, !exp_if); else passed++;
      @(posedge clk); #1;
      total++; if (if_rvalid !== exp_if || d_rvalid !== !exp_if) $display("FAIL collide_rvalid[%0d]: got if=%b d=%b want if=%b d=%b", i, if_rvalid, d_rvalid, exp_if, !exp_if); else passed++;
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 4'b1111, 32'h4000, 32'h5A5A5A5A);
    #1;
    total++; if (mem_addr !== 12'h000) $display("FAIL wrap_addr: got %h want 000", mem_addr); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A5A5A5A) $display("FAIL wrap_rdata: got v=%b d=%h want 1/5a5a5a5a", d_rvalid, d_rdata); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read;
    // Build up starvation, then grant a load and reset before its edge
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h4, 1'b1, 4'b0000, 32'h8, 32'h0);
    end
    #1;
    total++; if (d_ready !== 1'b1) $display("FAIL midrd_grant: got %b want 1", d_ready); else passed++;
    #3 rstn = 1'b0;
    #1;
    total++; if ({d_ready, mem_en} !== 2'b00) $display("FAIL midrd_suppress: got %b want 00", {d_ready, mem_en}); else passed++;
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b0) $display("FAIL midrd_rvalid: got %b want 0", d_rvalid); else passed++;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++; if (dut.starve_cnt !== 4'd0 || d_ready !== 1'b1) $display("FAIL midrd_cnt: got cnt=%0d d_ready=%b want 0/1", dut.starve_cnt, d_ready); else passed++;
    // rvalid already high when reset hits must drop at once
    @(posedge clk); #1;
    total++; if (d_rvalid !== 1'b1) $display("FAIL inflight_pre: got %b want 1", d_rvalid); else passed++;
    rstn = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL inflight_drop: got d=%b if=%b want 0/0", d_rvalid, if_rvalid); else passed++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    total++; if ({d_rvalid, if_rvalid, mem_en} !== 3'b000) $display("FAIL post_reset_quiet: got %b want 000", {d_rvalid, if_rvalid, mem_en}); else passed++;
  endtask

  initial begin
    for (int i = 0; i < (1 << MEM_ADDR_W); i++) ram[i] = 32'h0;
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
    mem_rdata = 32'h0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_collision();
    test_wrap();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
